// File: rtl/hci_mem_bank_responder.sv
// Single-port TCDM bank and responder for one HCI log-interconnect output port.
// It has 1-cycle registered responses, a grant throttle for backpressure, and verification counters.
module hci_mem_bank_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int BW    = 8,
  parameter int UW    = 0,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic [AW-1:0]      add_i,
  input  logic               we_n_i,
  input  logic [DW/BW-1:0]   be_i,
  input  logic [UW+DW-1:0]   wdata_i,
  output logic               gnt_o,
  output logic               r_valid_o,
  output logic [UW+DW-1:0]   r_rdata_o,
  input  logic               stall_en_i,
  input  logic [7:0]         stall_period_i,
  output logic [CNT_W-1:0]   n_reads_o,
  output logic [CNT_W-1:0]   n_writes_o,
  output logic               oob_o
);

  localparam int NBE = DW / BW;
  localparam int MW  = UW + DW;

  // Storage is deliberately left out of reset so contents survive rst_i.
  logic [MW-1:0] mem [DEPTH];

  logic [7:0]       stall_cnt_q, stall_cnt_d;
  logic             r_valid_q, r_valid_d;
  logic [MW-1:0]    r_rdata_q, r_rdata_d;
  logic [CNT_W-1:0] n_reads_q, n_reads_d;
  logic [CNT_W-1:0] n_writes_q, n_writes_d;
  logic             oob_q, oob_d;

  logic             throttle;
  logic             gnt;
  logic             in_range;
  logic             wr_en;
  logic [MW-1:0]    rd_word;
  logic [MW-1:0]    wr_word;

  assign in_range = (32'(add_i) < DEPTH);
  assign throttle = stall_en_i && (stall_period_i != 8'd0) && (stall_cnt_q == stall_period_i);
  assign gnt      = req_i && !throttle;
  assign wr_en    = gnt && !we_n_i && in_range;

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[add_i];
  end

  // User bits (above DW) follow every granted write; data lanes follow be_i.
  always_comb begin
    wr_word = rd_word;
    for (int k = 0; k < NBE; k++) begin
      if (be_i[k]) wr_word[k*BW +: BW] = wdata_i[k*BW +: BW];
    end
    for (int b = DW; b < MW; b++) begin
      wr_word[b] = wdata_i[b];
    end
  end

  // Idle cycles hold the throttle phase; a lowered period lets it run through 255 and wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_i) begin
      if (!stall_en_i || (stall_period_i == 8'd0)) begin
        stall_cnt_d = 8'd0;
      end else if (stall_cnt_q == stall_period_i) begin
        stall_cnt_d = 8'd0;
      end else begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    r_valid_d  = gnt;
    r_rdata_d  = r_rdata_q;
    n_reads_d  = n_reads_q;
    n_writes_d = n_writes_q;
    oob_d      = oob_q;
    if (gnt) begin
      if (we_n_i) begin
        r_rdata_d = rd_word;
        if (n_reads_q != {CNT_W{1'b1}}) n_reads_d = n_reads_q + CNT_W'(1);
      end else begin
        r_rdata_d = '0;
        if (n_writes_q != {CNT_W{1'b1}}) n_writes_d = n_writes_q + CNT_W'(1);
      end
      if (!in_range) oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 8'd0;
      r_valid_q   <= 1'b0;
      r_rdata_q   <= '0;
      n_reads_q   <= '0;
      n_writes_q  <= '0;
      oob_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      r_valid_q   <= r_valid_d;
      r_rdata_q   <= r_rdata_d;
      n_reads_q   <= n_reads_d;
      n_writes_q  <= n_writes_d;
      oob_q       <= oob_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[add_i] <= wr_word;
  end

  assign gnt_o      = gnt;
  assign r_valid_o  = r_valid_q;
  assign r_rdata_o  = r_rdata_q;
  assign n_reads_o  = n_reads_q;
  assign n_writes_o = n_writes_q;
  assign oob_o      = oob_q;

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Directed and randomized bench for hci_mem_bank_responder (DEPTH=1000, CNT_W=4 to reach saturation).
// Handshake: a transaction is accepted when req_i && gnt_o; its response appears with r_valid_o one cycle later.
module tb_hci_mem_bank_responder;

  localparam int DEPTH = 1000;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic [9:0]       add_i;
  logic             we_n_i;
  logic [3:0]       be_i;
  logic [31:0]      wdata_i;
  logic             gnt_o;
  logic             r_valid_o;
  logic [31:0]      r_rdata_o;
  logic             stall_en_i;
  logic [7:0]       stall_period_i;
  logic [CNT_W-1:0] n_reads_o;
  logic [CNT_W-1:0] n_writes_o;
  logic             oob_o;

  hci_mem_bank_responder #(.AW(10), .DEPTH(DEPTH), .DW(32), .BW(8), .UW(0), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .we_n_i(we_n_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .stall_en_i(stall_en_i), .stall_period_i(stall_period_i),
    .n_reads_o(n_reads_o), .n_writes_o(n_writes_o), .oob_o(oob_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q[$];
  int          m_reads, m_writes, m_n;
  logic        m_oob, m_en;
  int          m_p;
  logic        last_gnt;
  int          resp_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stall(input logic en, input int p);
    m_en = en;
    m_p  = p;
    stall_en_i     = en;
    stall_period_i = 8'(p);
  endtask

  // One clock cycle: drive, check grant, step the model, check the registered response.
  task automatic step(input logic req, input logic we_n, input logic [9:0] add,
                      input logic [3:0] be, input logic [31:0] wd, input int gexp);
    logic        g_exp;
    logic [31:0] d;
    req_i = req; we_n_i = we_n; add_i = add; be_i = be; wdata_i = wd;
    #1;
    if (gexp >= 0) g_exp = (gexp != 0);
    else g_exp = req && !(m_en && (m_p != 0) && ((m_n % (m_p + 1)) == m_p));
    chk("gnt", {63'd0, gnt_o}, {63'd0, g_exp});
    last_gnt = gnt_o;
    if (g_exp) begin
      if (!we_n) begin
        if (add < DEPTH) begin
          for (int k = 0; k < 4; k++) if (be[k]) ref_mem[add][8*k +: 8] = wd[8*k +: 8];
        end
        m_writes++;
        exp_q.push_back(32'd0);
      end else begin
        m_reads++;
        exp_q.push_back((add < DEPTH) ? ref_mem[add] : 32'd0);
      end
      if (add >= DEPTH) m_oob = 1'b1;
    end
    if (req) m_n = (m_en && (m_p != 0)) ? m_n + 1 : 0;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    if (r_valid_o === 1'b1) resp_cnt++;
    chk("r_valid", {63'd0, r_valid_o}, {63'd0, g_exp});
    if (g_exp) begin
      d = exp_q.pop_front();
      chk("r_rdata", {32'd0, r_rdata_o}, {32'd0, d});
    end
    chk("n_reads",  64'(n_reads_o),  64'((m_reads  > CMAX) ? CMAX : m_reads));
    chk("n_writes", 64'(n_writes_o), 64'((m_writes > CMAX) ? CMAX : m_writes));
    chk("oob", {63'd0, oob_o}, {63'd0, m_oob});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_reads = 0; m_writes = 0; m_n = 0; m_oob = 1'b0;
  endtask

  initial begin
    int   r0, refusals;
    logic [7:0] pat;
    int   p_tab [6];
    p_tab = '{0, 1, 2, 3, 7, 255};

    rst_i = 1'b1; req_i = 1'b0; add_i = '0; we_n_i = 1'b1; be_i = '0; wdata_i = '0;
    set_stall(1'b0, 0);
    model_reset();
    resp_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("rst_r_rdata", {32'd0, r_rdata_o}, 64'd0);
    chk("rst_n_reads", 64'(n_reads_o), 64'd0);
    chk("rst_n_writes", 64'(n_writes_o), 64'd0);
    chk("rst_oob", {63'd0, oob_o}, 64'd0);
    #1;
    chk("idle_gnt", {63'd0, gnt_o}, 64'd0);

    // full write then read
    step(1'b1, 1'b0, 10'd5, 4'hF, 32'hDEADBEEF, -1);
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
    chk("rd5_data", {32'd0, r_rdata_o}, 64'hDEADBEEF);
    chk("cnt_1_1", {32'(n_reads_o), 32'(n_writes_o)}, {32'd1, 32'd1});

    // partial write
    step(1'b1, 1'b0, 10'd5, 4'b0101, 32'h11223344, -1);
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
    chk("partial_data", {32'd0, r_rdata_o}, 64'hDE22BE44);

    // throttle P=3 over 8 requesting cycles
    set_stall(1'b1, 3);
    pat = '0;
    r0 = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
      pat[i] = last_gnt;
    end
    chk("stall_pattern", 64'(pat), 64'h77);
    chk("stall_resps", 64'(resp_cnt - r0), 64'd6);
    set_stall(1'b0, 0);
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);

    // back-to-back write then read of the same word
    step(1'b1, 1'b0, 10'd7, 4'hF, 32'hCAFE0007, -1);
    step(1'b1, 1'b1, 10'd7, 4'h0, 32'h0, -1);
    chk("b2b_data", {32'd0, r_rdata_o}, 64'hCAFE0007);

    // out-of-range read latches oob
    step(1'b1, 1'b1, 10'd1023, 4'h0, 32'h0, -1);
    chk("oob_rdata", {32'd0, r_rdata_o}, 64'd0);
    chk("oob_set", {63'd0, oob_o}, 64'd1);
    step(1'b1, 1'b0, 10'd999, 4'hF, 32'h99999999, -1);
    step(1'b1, 1'b1, 10'd7, 4'h0, 32'h0, -1);
    chk("oob_sticky", {63'd0, oob_o}, 64'd1);

    // period lowered below the running count: run through 255 and wrap
    set_stall(1'b1, 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
    set_stall(1'b1, 1);
    refusals = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, (i == 254) ? 0 : 1);
      if (!last_gnt) refusals++;
    end
    chk("lowered_refusals", 64'(refusals), 64'd1);
    set_stall(1'b0, 0);
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);

    // P=255: one refusal in 257 requesting cycles
    set_stall(1'b1, 255);
    refusals = 0;
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b1, 10'd7, 4'h0, 32'h0, -1);
      if (!last_gnt) refusals++;
    end
    chk("p255_refusals", 64'(refusals), 64'd1);
    set_stall(1'b0, 0);

    // randomized traffic on words 16..31 plus out-of-range addresses
    for (int a = 16; a < 32; a++) step(1'b1, 1'b0, 10'(a), 4'hF, $urandom, -1);
    for (int blk = 0; blk < 8; blk++) begin
      set_stall(1'b0, 0);
      step(1'b1, 1'b1, 10'(16 + $urandom_range(0, 15)), 4'h0, 32'h0, -1);
      set_stall(1'($urandom_range(0, 1)), p_tab[$urandom_range(0, 5)]);
      for (int i = 0; i < 40; i++) begin
        logic [9:0] a;
        if ($urandom_range(0, 7) == 0) a = 10'(DEPTH + $urandom_range(0, 23));
        else a = 10'(16 + $urandom_range(0, 15));
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
             4'($urandom_range(0, 15)), $urandom, -1);
      end
    end
    set_stall(1'b0, 0);

    // reset with a response pending, then storage must survive
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
    req_i = 1'b1; we_n_i = 1'b1; add_i = 10'd5; rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; req_i = 1'b0;
    model_reset();
    chk("rst2_r_valid", {63'd0, r_valid_o}, 64'd0);
    chk("rst2_counters", {32'(n_reads_o), 32'(n_writes_o)}, 64'd0);
    chk("rst2_oob", {63'd0, oob_o}, 64'd0);
    step(1'b1, 1'b1, 10'd5, 4'h0, 32'h0, -1);
    chk("persist_data", {32'd0, r_rdata_o}, 64'hDE22BE44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
